serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around the single-bit
// full_adder. Operands are consumed LSB first, one bit per clock, with a
// start/busy/done handshake and a registered result {cout, sum} = a + b + cin.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf output
// (two's-complement signed overflow, captured alongside sum/cout).

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic             w_fa_sum;
    logic             w_fa_carry;
    logic [WIDTH-1:0] w_res_next;

    full_adder u_fa (
        .a     (r_a_sr[0]),
        .b     (r_b_sr[0]),
        .c     (r_carry),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    assign w_res_next = {w_fa_sum, r_res_sr[WIDTH-1:1]};

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    r_res_sr <= w_res_next;
                    r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_carry  <= w_fa_carry;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_carry here is the carry into the MSB position
                        r_ovf   <= r_carry ^ w_fa_carry;
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl (WIDTH=8).
// Driver pushes accepted operations into a queue; a negedge monitor pops and
// checks result, completion cycle, busy/done timing and result hold.

module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        int           k;
    } op_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
    logic         exp_ovf_hold;
`endif

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    op_t          q[$];
    bit           have_op  = 0;
    int           last_k   = 0;
    logic [W-1:0] exp_sum_hold;
    logic         exp_cout_hold;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result from plain integer arithmetic
    function automatic int ref_full(input op_t op);
        return int'(op.a) + int'(op.b) + int'(op.c);
    endfunction

    function automatic bit ref_ovf(input op_t op);
        int s;
        s = int'($signed(op.a)) + int'($signed(op.b)) + int'(op.c);
        return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    endfunction

    // Monitor: compare DUT against scoreboard once per cycle
    always @(negedge clk) begin
        if (rst_n) begin
            op_t op;
            int  full;
            bit  exp_busy;
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    op   = q.pop_front();
                    full = ref_full(op);
                    check("done_cycle", cyc, op.k + W);
                    check("sum", sum, full[W-1:0]);
                    check("cout", cout, full[W]);
                    exp_sum_hold  = full[W-1:0];
                    exp_cout_hold = full[W];
`ifdef SERIAL_ADDER_OVF_EN
                    check("ovf", ovf, ref_ovf(op));
                    exp_ovf_hold = ref_ovf(op);
`endif
                end
            end else begin
                check("sum_hold", sum, exp_sum_hold);
                check("cout_hold", cout, exp_cout_hold);
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf_hold", ovf, exp_ovf_hold);
`endif
                if (q.size() > 0 && cyc > q[0].k + W) begin
                    check("done_timeout", cyc, q[0].k + W);
                    void'(q.pop_front());
                end
            end
            exp_busy = (q.size() > 0) && (q[0].k <= cyc) && (cyc < q[0].k + W);
            check("busy", busy, exp_busy);
        end
    end

    // One clock of stimulus; called just after a negedge
    task automatic drive(input bit st, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc);
        int  e;
        op_t op;
        start = st;
        a     = va;
        b     = vb;
        cin   = vc;
        e     = cyc + 1;
        if (st && (!have_op || e >= last_k + W + 1)) begin
            op.a = va;
            op.b = vb;
            op.c = vc;
            op.k = e;
            q.push_back(op);
            have_op = 1;
            last_k  = e;
        end
        @(negedge clk);
    endtask

    task automatic idle_until_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            drive(0, '0, '0, 0);
            n++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
        drive(0, '0, '0, 0);
    endtask

    task automatic reset_checks();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
    endtask

    task automatic clear_model();
        q.delete();
        have_op       = 0;
        exp_sum_hold  = '0;
        exp_cout_hold = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        exp_ovf_hold  = 1'b0;
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        clear_model();
        #1;
        reset_checks();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations
        drive(1, 8'h00, 8'h00, 0);
        idle_until_empty();
        drive(1, 8'h5A, 8'h33, 1);
        idle_until_empty();
        drive(1, 8'hFF, 8'h01, 0);
        idle_until_empty();

        // Start while busy is ignored
        drive(1, 8'h0F, 8'h01, 0);
        drive(1, 8'h11, 8'h22, 0);
        idle_until_empty();

        // Start held high through DONE: back-to-back accept
        drive(1, 8'h01, 8'h01, 0);
        for (int i = 0; i <= W; i++) drive(1, 8'h80, 8'h80, 0);
        idle_until_empty();

        // Asynchronous reset in cycle 4 of an add
        drive(1, 8'hA5, 8'h3C, 1);
        repeat (3) drive(0, '0, '0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks();
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1, 8'h01, 8'h02, 0);
        idle_until_empty();

        // Signed overflow corners
        drive(1, 8'h7F, 8'h01, 0);
        idle_until_empty();
        drive(1, 8'hFF, 8'h01, 0);
        idle_until_empty();
        drive(1, 8'h80, 8'hFF, 1);
        idle_until_empty();

        // Random traffic with random start pattern
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                  1'($urandom_range(0, 1)));
        end
        idle_until_empty();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
